// File: rtl/pcie_rx_tag_ring.sv
// pcie_rx_tag_ring: completion-tag tracker for PCIe read completions.
// Each issued read claims a ring slot holding its tag, FIFO base address
// and expected beat count. Completion beats are steered to base + beats
// received, and slots retire strictly in issue order, moving rear_addr.
// Optional completion timeout: define PCIE_TAG_TIMEOUT_EN.
module pcie_rx_tag_ring #(
    parameter int C_PCIE_DATA_WIDTH  = 512,
    parameter int P_FIFO_DEPTH_WIDTH = 4,
    parameter int P_NUM_TAGS_WIDTH   = 2,
    parameter int P_TAG_WIDTH        = 3,
    parameter int P_LEN_WIDTH        = 3,
    parameter int P_TIMEOUT_CYCLES   = 4096
) (
    input  logic                               pcie_user_clk,
    input  logic                               pcie_user_rst_n,
    input  logic                               pcie_tag_alloc,
    input  logic [7:0]                         pcie_alloc_tag,
    input  logic [P_LEN_WIDTH-1:0]             pcie_tag_alloc_len,
    output logic                               pcie_tag_full_n,
    input  logic [7:0]                         cpld_fifo_tag,
    input  logic                               cpld_fifo_wr_en,
    input  logic [C_PCIE_DATA_WIDTH-1:0]       cpld_fifo_wr_data,
    input  logic                               cpld_fifo_tag_last,
    output logic                               fifo_wr_en,
    output logic [P_FIFO_DEPTH_WIDTH-1:0]      fifo_wr_addr,
    output logic [C_PCIE_DATA_WIDTH-1:0]       fifo_wr_data,
    output logic [P_FIFO_DEPTH_WIDTH:0]        rear_full_addr,
    output logic [P_FIFO_DEPTH_WIDTH:0]        rear_addr,
    output logic                               tag_err,
    output logic [1:0]                         tag_err_code
);

    localparam int NUM_SLOTS = 1 << P_NUM_TAGS_WIDTH;
    localparam int SW        = P_NUM_TAGS_WIDTH;
    localparam int AW        = P_FIFO_DEPTH_WIDTH + 1;

    // Ring pointers carry an extra wrap bit to tell full from empty.
    logic [SW:0]                              rear_ptr, front_ptr;
    logic [SW-1:0]                            rear_idx, front_idx;

    logic [NUM_SLOTS-1:0]                     slot_vld, slot_done;
    logic [NUM_SLOTS-1:0][P_TAG_WIDTH-1:0]    slot_tag;
    logic [NUM_SLOTS-1:0][AW-1:0]             slot_base;
    logic [NUM_SLOTS-1:0][P_LEN_WIDTH-1:0]    slot_len, slot_rcvd;

    logic [NUM_SLOTS-1:0]                     hit;
    logic                                     hit_any;
    logic [SW-1:0]                            hit_idx;
    logic [AW-1:0]                            beat_addr;

    logic alloc_fire, beat_ok, beat_ovr, beat_miss, retire_fire, to_fire;

    // Upper tag bits are ignored for matching.
    logic unused_tag_bits;
    assign unused_tag_bits = ^{cpld_fifo_tag[7:P_TAG_WIDTH], pcie_alloc_tag[7:P_TAG_WIDTH]};

    assign rear_idx        = rear_ptr[SW-1:0];
    assign front_idx       = front_ptr[SW-1:0];
    assign pcie_tag_full_n = ~((rear_idx == front_idx) && (rear_ptr[SW] != front_ptr[SW]));
    assign alloc_fire      = pcie_tag_alloc & pcie_tag_full_n;
    assign retire_fire     = slot_vld[front_idx] & slot_done[front_idx];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_hit
            assign hit[gi] = slot_vld[gi] & ~slot_done[gi] &
                             (slot_tag[gi] == cpld_fifo_tag[P_TAG_WIDTH-1:0]);
        end
    endgenerate

    // Lowest matching slot wins if upstream ever duplicates a tag.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_any = 1'b1;
                hit_idx = SW'(i);
            end
        end
    end

    assign beat_addr = slot_base[hit_idx] + AW'(slot_rcvd[hit_idx]);
    assign beat_ok   = cpld_fifo_wr_en & hit_any & (slot_rcvd[hit_idx] < slot_len[hit_idx]);
    assign beat_ovr  = cpld_fifo_wr_en & hit_any & ~(slot_rcvd[hit_idx] < slot_len[hit_idx]);
    assign beat_miss = cpld_fifo_wr_en & ~hit_any;

`ifdef PCIE_TAG_TIMEOUT_EN
    localparam int TW = $clog2(P_TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] to_cnt;

    assign to_fire = slot_vld[front_idx] & ~slot_done[front_idx] &
                     (to_cnt == TW'(P_TIMEOUT_CYCLES - 1));

    // Count cycles the oldest slot has waited; idle or done front resets it.
    always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
        if (!pcie_user_rst_n)
            to_cnt <= '0;
        else if (slot_vld[front_idx] && !slot_done[front_idx] && !to_fire)
            to_cnt <= to_cnt + TW'(1);
        else
            to_cnt <= '0;
    end
`else
    assign to_fire = 1'b0;
`endif

    // Slot table: allocate at rear, count accepted beats, retire at front.
    always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
        if (!pcie_user_rst_n) begin
            slot_vld  <= '0;
            slot_done <= '0;
            slot_tag  <= '0;
            slot_base <= '0;
            slot_len  <= '0;
            slot_rcvd <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                // A slot being allocated is invalid, so no other event can touch it.
                if (alloc_fire && rear_idx == SW'(i)) begin
                    slot_vld[i]  <= 1'b1;
                    slot_done[i] <= 1'b0;
                    slot_tag[i]  <= pcie_alloc_tag[P_TAG_WIDTH-1:0];
                    slot_base[i] <= rear_full_addr;
                    slot_len[i]  <= pcie_tag_alloc_len;
                    slot_rcvd[i] <= '0;
                end else begin
                    if (retire_fire && front_idx == SW'(i))
                        slot_vld[i] <= 1'b0;
                    if (beat_ok && hit_idx == SW'(i)) begin
                        slot_rcvd[i] <= slot_rcvd[i] + P_LEN_WIDTH'(1);
                        if (cpld_fifo_tag_last)
                            slot_done[i] <= 1'b1;
                    end
                    if (to_fire && front_idx == SW'(i))
                        slot_done[i] <= 1'b1;
                end
            end
        end
    end

    // Ring pointers and the two consumer-visible FIFO pointers.
    always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
        if (!pcie_user_rst_n) begin
            rear_ptr       <= '0;
            front_ptr      <= '0;
            rear_full_addr <= '0;
            rear_addr      <= '0;
        end else begin
            if (alloc_fire) begin
                rear_ptr       <= rear_ptr + (SW+1)'(1);
                rear_full_addr <= rear_full_addr + AW'(pcie_tag_alloc_len);
            end
            if (retire_fire) begin
                front_ptr <= front_ptr + (SW+1)'(1);
                rear_addr <= slot_base[front_idx] + AW'(slot_len[front_idx]);
            end
        end
    end

    // Registered FIFO write port and error pulse; timeout outranks beat errors.
    always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
        if (!pcie_user_rst_n) begin
            fifo_wr_en   <= 1'b0;
            fifo_wr_addr <= '0;
            fifo_wr_data <= '0;
            tag_err      <= 1'b0;
            tag_err_code <= 2'b00;
        end else begin
            fifo_wr_en <= beat_ok;
            if (beat_ok) begin
                fifo_wr_addr <= beat_addr[AW-2:0];
                fifo_wr_data <= cpld_fifo_wr_data;
            end
            tag_err <= to_fire | beat_miss | beat_ovr;
            if (to_fire)
                tag_err_code <= 2'b11;
            else if (beat_miss)
                tag_err_code <= 2'b01;
            else if (beat_ovr)
                tag_err_code <= 2'b10;
            else
                tag_err_code <= 2'b00;
        end
    end

endmodule

// File: tb/tb_pcie_rx_tag_ring.sv
// Directed bench for pcie_rx_tag_ring at default parameters (16-beat FIFO,
// 4 slots) with P_TIMEOUT_CYCLES = 16; timeout case under PCIE_TAG_TIMEOUT_EN.
module tb_pcie_rx_tag_ring;

    localparam int DW = 512;

    logic           pcie_user_clk;
    logic           pcie_user_rst_n;
    logic           pcie_tag_alloc;
    logic [7:0]     pcie_alloc_tag;
    logic [2:0]     pcie_tag_alloc_len;
    logic           pcie_tag_full_n;
    logic [7:0]     cpld_fifo_tag;
    logic           cpld_fifo_wr_en;
    logic [DW-1:0]  cpld_fifo_wr_data;
    logic           cpld_fifo_tag_last;
    logic           fifo_wr_en;
    logic [3:0]     fifo_wr_addr;
    logic [DW-1:0]  fifo_wr_data;
    logic [4:0]     rear_full_addr;
    logic [4:0]     rear_addr;
    logic           tag_err;
    logic [1:0]     tag_err_code;

    int errs   = 0;
    int checks = 0;

    pcie_rx_tag_ring #(
        .C_PCIE_DATA_WIDTH (DW),
        .P_FIFO_DEPTH_WIDTH(4),
        .P_NUM_TAGS_WIDTH  (2),
        .P_TAG_WIDTH       (3),
        .P_LEN_WIDTH       (3),
        .P_TIMEOUT_CYCLES  (16)
    ) dut (
        .pcie_user_clk     (pcie_user_clk),
        .pcie_user_rst_n   (pcie_user_rst_n),
        .pcie_tag_alloc    (pcie_tag_alloc),
        .pcie_alloc_tag    (pcie_alloc_tag),
        .pcie_tag_alloc_len(pcie_tag_alloc_len),
        .pcie_tag_full_n   (pcie_tag_full_n),
        .cpld_fifo_tag     (cpld_fifo_tag),
        .cpld_fifo_wr_en   (cpld_fifo_wr_en),
        .cpld_fifo_wr_data (cpld_fifo_wr_data),
        .cpld_fifo_tag_last(cpld_fifo_tag_last),
        .fifo_wr_en        (fifo_wr_en),
        .fifo_wr_addr      (fifo_wr_addr),
        .fifo_wr_data      (fifo_wr_data),
        .rear_full_addr    (rear_full_addr),
        .rear_addr         (rear_addr),
        .tag_err           (tag_err),
        .tag_err_code      (tag_err_code)
    );

    initial pcie_user_clk = 1'b0;
    always #5 pcie_user_clk = ~pcie_user_clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int n);
        logic [31:0] w;
        w = 32'hA500_0000 | 32'(n);
        return {16{w}};
    endfunction

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge pcie_user_clk);
        #1;
    endtask

    task automatic do_reset();
        pcie_tag_alloc     = 1'b0;
        cpld_fifo_wr_en    = 1'b0;
        cpld_fifo_tag_last = 1'b0;
        pcie_user_rst_n    = 1'b0;
        tick();
        pcie_user_rst_n    = 1'b1;
    endtask

    task automatic alloc_req(input logic [7:0] tag, input logic [2:0] len);
        pcie_tag_alloc     = 1'b1;
        pcie_alloc_tag     = tag;
        pcie_tag_alloc_len = len;
        tick();
        pcie_tag_alloc     = 1'b0;
    endtask

    task automatic beat(input logic [7:0] tag, input int id, input logic lst);
        cpld_fifo_wr_en    = 1'b1;
        cpld_fifo_tag      = tag;
        cpld_fifo_wr_data  = mk(id);
        cpld_fifo_tag_last = lst;
        tick();
        cpld_fifo_wr_en    = 1'b0;
        cpld_fifo_tag_last = 1'b0;
    endtask

    // Send an accepted beat and check the write it produces one cycle later.
    task automatic beat_exp(input string nm, input logic [7:0] tag, input int id,
                            input logic lst, input logic [3:0] addr);
        logic [DW-1:0] d;
        d = mk(id);
        beat(tag, id, lst);
        chk({nm, "_en"},   64'(fifo_wr_en), 64'd1);
        chk({nm, "_addr"}, 64'(fifo_wr_addr), 64'(addr));
        chk({nm, "_dlo"},  fifo_wr_data[63:0], d[63:0]);
        chk({nm, "_dhi"},  fifo_wr_data[DW-1:DW-64], d[DW-1:DW-64]);
    endtask

    initial begin
        int seen;
        pcie_alloc_tag     = 8'h0;
        pcie_tag_alloc_len = 3'd0;
        cpld_fifo_tag      = 8'h0;
        cpld_fifo_wr_data  = '0;

        // Reset values
        do_reset();
        chk("rst_full_n",    64'(pcie_tag_full_n), 64'd1);
        chk("rst_rear_full", 64'(rear_full_addr), 64'd0);
        chk("rst_rear",      64'(rear_addr), 64'd0);
        chk("rst_wr_en",     64'(fifo_wr_en), 64'd0);
        chk("rst_err",       64'(tag_err), 64'd0);
        chk("rst_code",      64'(tag_err_code), 64'd0);

        // Basic two-beat request
        alloc_req(8'h05, 3'd2);
        chk("t1_rear_full", 64'(rear_full_addr), 64'd2);
        beat_exp("t1_b0", 8'h05, 1, 1'b0, 4'd0);
        beat_exp("t1_b1", 8'h05, 2, 1'b1, 4'd1);
        chk("t1_rear_pre", 64'(rear_addr), 64'd0);
        tick();
        chk("t1_rear", 64'(rear_addr), 64'd2);
        chk("t1_wr_idle", 64'(fifo_wr_en), 64'd0);

        // Fill the ring, overflow alloc ignored, retire frees a slot
        do_reset();
        for (int i = 0; i < 4; i++) alloc_req(8'(i), 3'd1);
        chk("t2_full_n", 64'(pcie_tag_full_n), 64'd0);
        chk("t2_rear_full", 64'(rear_full_addr), 64'd4);
        alloc_req(8'h04, 3'd1);
        chk("t2_ovf_rear_full", 64'(rear_full_addr), 64'd4);
        chk("t2_ovf_full_n", 64'(pcie_tag_full_n), 64'd0);
        chk("t2_ovf_err", 64'(tag_err), 64'd0);
        beat_exp("t2_b", 8'h00, 3, 1'b1, 4'd0);
        tick();
        chk("t2_full_n_up", 64'(pcie_tag_full_n), 64'd1);
        chk("t2_rear", 64'(rear_addr), 64'd1);

        // Out-of-order completion waits for the older slot
        do_reset();
        alloc_req(8'h01, 3'd1);
        alloc_req(8'h02, 3'd1);
        beat_exp("t3_b2", 8'h02, 4, 1'b1, 4'd1);
        beat_exp("t3_b1", 8'h01, 5, 1'b1, 4'd0);
        chk("t3_rear0", 64'(rear_addr), 64'd0);
        tick();
        chk("t3_rear1", 64'(rear_addr), 64'd1);
        tick();
        chk("t3_rear2", 64'(rear_addr), 64'd2);

        // Unmatched tag and overrun errors
        do_reset();
        beat(8'h07, 6, 1'b0);
        chk("t4_miss_wr", 64'(fifo_wr_en), 64'd0);
        chk("t4_miss_err", 64'(tag_err), 64'd1);
        chk("t4_miss_code", 64'(tag_err_code), 64'd1);
        tick();
        chk("t4_err_pulse", 64'(tag_err), 64'd0);
        alloc_req(8'h03, 3'd2);
        beat_exp("t4_b0", 8'h03, 7, 1'b0, 4'd0);
        beat_exp("t4_b1", 8'h03, 8, 1'b0, 4'd1);
        beat(8'h03, 9, 1'b0);
        chk("t4_ovr_wr", 64'(fifo_wr_en), 64'd0);
        chk("t4_ovr_err", 64'(tag_err), 64'd1);
        chk("t4_ovr_code", 64'(tag_err_code), 64'd2);

        // FIFO address wrap at depth 16
        do_reset();
        for (int i = 0; i < 4; i++) alloc_req(8'(i), 3'd3);
        chk("t5_rear_full12", 64'(rear_full_addr), 64'd12);
        beat_exp("t5_a0", 8'h00, 10, 1'b0, 4'd0);
        beat_exp("t5_a1", 8'h00, 11, 1'b0, 4'd1);
        beat_exp("t5_a2", 8'h00, 12, 1'b1, 4'd2);
        beat_exp("t5_b0", 8'h01, 13, 1'b0, 4'd3);
        chk("t5_rear3", 64'(rear_addr), 64'd3);
        beat_exp("t5_b1", 8'h01, 14, 1'b0, 4'd4);
        beat_exp("t5_b2", 8'h01, 15, 1'b1, 4'd5);
        tick();
        chk("t5_rear6", 64'(rear_addr), 64'd6);
        alloc_req(8'h04, 3'd3);
        chk("t5_rear_full15", 64'(rear_full_addr), 64'd15);
        alloc_req(8'h05, 3'd3);
        chk("t5_rear_full18", 64'(rear_full_addr), 64'd18);
        chk("t5_full_n", 64'(pcie_tag_full_n), 64'd0);
        beat_exp("t5_f0", 8'h05, 16, 1'b0, 4'd15);
        beat_exp("t5_f1", 8'h05, 17, 1'b0, 4'd0);
        beat_exp("t5_f2", 8'h05, 18, 1'b1, 4'd1);

        // Reset mid-operation discards outstanding state
        do_reset();
        chk("t6_rear_full", 64'(rear_full_addr), 64'd0);
        chk("t6_rear", 64'(rear_addr), 64'd0);
        chk("t6_full_n", 64'(pcie_tag_full_n), 64'd1);
        chk("t6_wr_en", 64'(fifo_wr_en), 64'd0);
        beat(8'h05, 19, 1'b1);
        chk("t6_stale_tag_err", 64'(tag_err_code), 64'd1);

        // Stalled request: timeout when enabled, otherwise waits forever
        do_reset();
        alloc_req(8'h02, 3'd3);
        seen = 0;
`ifdef PCIE_TAG_TIMEOUT_EN
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (tag_err) begin
                seen = k;
                break;
            end
        end
        chk("t7_to_cycles", 64'(seen), 64'd16);
        chk("t7_to_code", 64'(tag_err_code), 64'd3);
        tick();
        chk("t7_to_rear", 64'(rear_addr), 64'd3);
        chk("t7_to_pulse", 64'(tag_err), 64'd0);
`else
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (tag_err) seen++;
        end
        chk("t7_no_err", 64'(seen), 64'd0);
        chk("t7_rear_held", 64'(rear_addr), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
